// File: rtl/conv_ofm_receiver_pkg.sv
// Shared types and constants for the OFM receive buffer.
package conv_ofm_receiver_pkg;
  typedef enum logic [1:0] {IDLE, ACCEPT, HANDOFF, WAIT_NEXT} state_e;
  localparam int LANES     = 3;
  localparam int MAX_GROUP = 5;
  localparam int ADDR_W    = 7;
endpackage

// File: rtl/conv_ofm_bank.sv
// One feature map: single write port, two independent registered read ports.
module conv_ofm_bank #(
  parameter int DEPTH      = 100,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = 7
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  ra_en_i,
  input  logic [AW-1:0]         ra_addr_i,
  output logic [DATA_WIDTH-1:0] ra_data_o,
  input  logic                  rb_en_i,
  input  logic [AW-1:0]         rb_addr_i,
  output logic [DATA_WIDTH-1:0] rb_data_o
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ra_q, rb_q;

  // Reads sample mem before this edge's write lands, so same-cycle RAW sees the old word.
  always_ff @(posedge clk) begin
    if (we_i && 32'(waddr_i) < DEPTH) mem[waddr_i] <= wdata_i;
    if (ra_en_i) ra_q <= (32'(ra_addr_i) < DEPTH) ? mem[ra_addr_i] : '0;
    if (rb_en_i) rb_q <= (32'(rb_addr_i) < DEPTH) ? mem[rb_addr_i] : '0;
  end

  assign ra_data_o = ra_q;
  assign rb_data_o = rb_q;
endmodule

// File: rtl/conv_ofm_receiver.sv
// Double-handshake OFM buffer: producer fills NUM_MAPS maps three lanes at a time, downstream reads by map.
module conv_ofm_receiver
  import conv_ofm_receiver_pkg::*;
#(
  parameter int MAP_SIZE   = 10,
  parameter int NUM_MAPS   = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_from_previous,
  output logic                  end_to_previous,
  input  logic                  ifm_enable_write_previous,
  input  logic [ADDR_W-1:0]     ifm_address_write_previous,
  input  logic [2:0]            ifm_sel_previous,
  input  logic [DATA_WIDTH-1:0] data_in_from_previous1,
  input  logic [DATA_WIDTH-1:0] data_in_from_previous2,
  input  logic [DATA_WIDTH-1:0] data_in_from_previous3,
  input  logic                  ifm_enable_read_previous,
  input  logic [ADDR_W-1:0]     ifm_address_read_previous,
  output logic [DATA_WIDTH-1:0] data_out_for_previous1,
  output logic [DATA_WIDTH-1:0] data_out_for_previous2,
  output logic [DATA_WIDTH-1:0] data_out_for_previous3,
  output logic                  start_to_next,
  input  logic                  end_from_next,
  input  logic                  ifm_enable_read_next,
  input  logic [3:0]            ifm_map_sel_next,
  input  logic [ADDR_W-1:0]     ifm_address_read_next,
  output logic [DATA_WIDTH-1:0] data_out_for_next,
  output logic                  write_error
);
  localparam int DEPTH = MAP_SIZE * MAP_SIZE;
  localparam int MW    = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1;

  state_e state_q;
  logic   end_q, stn_q, err_q;
  logic   grp_ok, waddr_ok, accepting, wr_ok, nxt_ok_d;

  logic [LANES-1:0][DATA_WIDTH-1:0] lane_wd;
  logic [LANES-1:0][5:0]            lane_map;
  logic [LANES-1:0]                 prd_ok_d, prd_ok_q;
  logic [LANES-1:0][MW-1:0]         prd_map_q;
  logic                             nxt_ok_q;
  logic [MW-1:0]                    nxt_map_q;

  logic [NUM_MAPS-1:0]                 bank_we, bank_ra_en, bank_rb_en;
  logic [NUM_MAPS-1:0][DATA_WIDTH-1:0] bank_wd, bank_ra, bank_rb;

  assign lane_wd   = {data_in_from_previous3, data_in_from_previous2, data_in_from_previous1};
  assign grp_ok    = 32'(ifm_sel_previous) <= MAX_GROUP;
  assign waddr_ok  = 32'(ifm_address_write_previous) < DEPTH;
  assign accepting = (state_q == IDLE) || (state_q == ACCEPT);
  assign wr_ok     = ifm_enable_write_previous && accepting && waddr_ok && grp_ok && !reset;
  assign nxt_ok_d  = 32'(ifm_map_sel_next) < NUM_MAPS;

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_map[l] = 6'(ifm_sel_previous) * 6'(LANES) + 6'(l);
      prd_ok_d[l] = grp_ok && (32'(lane_map[l]) < NUM_MAPS);
    end
  end

  // Lane-to-bank steering; lanes that land past NUM_MAPS match no bank and fall away.
  always_comb begin
    for (int m = 0; m < NUM_MAPS; m++) begin
      bank_we[m]    = 1'b0;
      bank_wd[m]    = '0;
      bank_ra_en[m] = 1'b0;
      bank_rb_en[m] = ifm_enable_read_next && (32'(ifm_map_sel_next) == m);
      for (int l = 0; l < LANES; l++) begin
        if (lane_map[l] == 6'(m)) begin
          bank_we[m]    = wr_ok;
          bank_wd[m]    = lane_wd[l];
          bank_ra_en[m] = ifm_enable_read_previous && grp_ok;
        end
      end
    end
  end

  for (genvar m = 0; m < NUM_MAPS; m++) begin : g_bank
    conv_ofm_bank #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(ADDR_W)) u_bank (
      .clk       (clk),
      .we_i      (bank_we[m]),
      .waddr_i   (ifm_address_write_previous),
      .wdata_i   (bank_wd[m]),
      .ra_en_i   (bank_ra_en[m]),
      .ra_addr_i (ifm_address_read_previous),
      .ra_data_o (bank_ra[m]),
      .rb_en_i   (bank_rb_en[m]),
      .rb_addr_i (ifm_address_read_next),
      .rb_data_o (bank_rb[m])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      end_q   <= 1'b1;
      stn_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      stn_q <= 1'b0;
      if (ifm_enable_write_previous && !wr_ok) err_q <= 1'b1;
      case (state_q)
        IDLE, ACCEPT: begin
          if (start_from_previous) begin
            state_q <= HANDOFF;
            stn_q   <= 1'b1;
            end_q   <= 1'b0;
          end else if (wr_ok) begin
            state_q <= ACCEPT;
          end
        end
        HANDOFF: state_q <= WAIT_NEXT;
        WAIT_NEXT: begin
          if (end_from_next) begin
            state_q <= IDLE;
            end_q   <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Output selectors only move on a strobe, so read data holds while the strobe is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      prd_ok_q  <= '0;
      prd_map_q <= '0;
      nxt_ok_q  <= 1'b0;
      nxt_map_q <= '0;
    end else begin
      if (ifm_enable_read_previous) begin
        prd_ok_q <= prd_ok_d;
        for (int l = 0; l < LANES; l++) prd_map_q[l] <= MW'(lane_map[l]);
      end
      if (ifm_enable_read_next) begin
        nxt_ok_q  <= nxt_ok_d;
        nxt_map_q <= MW'(ifm_map_sel_next);
      end
    end
  end

  assign data_out_for_previous1 = prd_ok_q[0] ? bank_ra[prd_map_q[0]] : '0;
  assign data_out_for_previous2 = prd_ok_q[1] ? bank_ra[prd_map_q[1]] : '0;
  assign data_out_for_previous3 = prd_ok_q[2] ? bank_ra[prd_map_q[2]] : '0;
  assign data_out_for_next      = nxt_ok_q ? bank_rb[nxt_map_q] : '0;
  assign end_to_previous        = end_q;
  assign start_to_next          = stn_q;
  assign write_error            = err_q;
endmodule

// File: tb/tb_conv_ofm_receiver.sv
// Directed bench for conv_ofm_receiver: handshake, lane steering, error flag, full-buffer sweep.
module tb_conv_ofm_receiver;
  logic        clk = 1'b0, reset = 1'b1;
  logic        start_from_previous = 0, end_to_previous;
  logic        ifm_enable_write_previous = 0;
  logic [6:0]  ifm_address_write_previous = '0;
  logic [2:0]  ifm_sel_previous = '0;
  logic [31:0] data_in_from_previous1 = '0, data_in_from_previous2 = '0, data_in_from_previous3 = '0;
  logic        ifm_enable_read_previous = 0;
  logic [6:0]  ifm_address_read_previous = '0;
  logic [31:0] data_out_for_previous1, data_out_for_previous2, data_out_for_previous3;
  logic        start_to_next, end_from_next = 0, ifm_enable_read_next = 0;
  logic [3:0]  ifm_map_sel_next = '0;
  logic [6:0]  ifm_address_read_next = '0;
  logic [31:0] data_out_for_next;
  logic        write_error;

  int vecs = 0, errs = 0;

  conv_ofm_receiver dut (
    .clk(clk), .reset(reset),
    .start_from_previous(start_from_previous), .end_to_previous(end_to_previous),
    .ifm_enable_write_previous(ifm_enable_write_previous),
    .ifm_address_write_previous(ifm_address_write_previous),
    .ifm_sel_previous(ifm_sel_previous),
    .data_in_from_previous1(data_in_from_previous1),
    .data_in_from_previous2(data_in_from_previous2),
    .data_in_from_previous3(data_in_from_previous3),
    .ifm_enable_read_previous(ifm_enable_read_previous),
    .ifm_address_read_previous(ifm_address_read_previous),
    .data_out_for_previous1(data_out_for_previous1),
    .data_out_for_previous2(data_out_for_previous2),
    .data_out_for_previous3(data_out_for_previous3),
    .start_to_next(start_to_next), .end_from_next(end_from_next),
    .ifm_enable_read_next(ifm_enable_read_next), .ifm_map_sel_next(ifm_map_sel_next),
    .ifm_address_read_next(ifm_address_read_next), .data_out_for_next(data_out_for_next),
    .write_error(write_error)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(int m, int a);
    return 32'h5A00_0000 ^ 32'((m << 16) | a);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int g, input int a, input logic [31:0] d1, d2, d3);
    ifm_enable_write_previous = 1; ifm_sel_previous = 3'(g); ifm_address_write_previous = 7'(a);
    data_in_from_previous1 = d1; data_in_from_previous2 = d2; data_in_from_previous3 = d3;
    tick();
    ifm_enable_write_previous = 0;
  endtask

  task automatic read_prev(input int g, input int a);
    ifm_enable_read_previous = 1; ifm_sel_previous = 3'(g); ifm_address_read_previous = 7'(a);
    tick();
    ifm_enable_read_previous = 0;
  endtask

  task automatic read_next(input int m, input int a, output logic [31:0] d);
    ifm_enable_read_next = 1; ifm_map_sel_next = 4'(m); ifm_address_read_next = 7'(a);
    tick();
    d = data_out_for_next;
    ifm_enable_read_next = 0;
  endtask

  task automatic do_reset();
    reset = 1; tick(); reset = 0;
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    vecs++;
    if (act !== exp) begin errs++; $display("FAIL %s: got %0b expected %0b", nm, act, exp); end
  endtask

  task automatic test_reset();
    do_reset();
    chk1("rst_end_to_previous", end_to_previous, 1'b1);
    chk1("rst_start_to_next", start_to_next, 1'b0);
    chk1("rst_write_error", write_error, 1'b0);
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3, data_out_for_next} !== '0) begin
      errs++; $display("FAIL rst_data: got %h %h %h %h expected all 0", data_out_for_previous1,
                       data_out_for_previous2, data_out_for_previous3, data_out_for_next);
    end
  endtask

  task automatic test_basic();
    do_write(0, 0, 32'd1, 32'd2, 32'd3);
    read_prev(0, 0);
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3} !== {32'd1, 32'd2, 32'd3}) begin
      errs++; $display("FAIL basic_read: got %0d %0d %0d expected 1 2 3",
                       data_out_for_previous1, data_out_for_previous2, data_out_for_previous3);
    end
    tick();
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3} !== {32'd1, 32'd2, 32'd3}) begin
      errs++; $display("FAIL basic_hold: got %0d %0d %0d expected 1 2 3",
                       data_out_for_previous1, data_out_for_previous2, data_out_for_previous3);
    end
    chk1("accept_end_to_previous", end_to_previous, 1'b1);
  endtask

  task automatic test_read_during_write();
    do_write(0, 1, 32'd10, 32'd11, 32'd12);
    ifm_enable_read_previous = 1; ifm_address_read_previous = 7'd1;
    do_write(0, 1, 32'd20, 32'd21, 32'd22);
    ifm_enable_read_previous = 0;
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3} !== {32'd10, 32'd11, 32'd12}) begin
      errs++; $display("FAIL rdw_old: got %0d %0d %0d expected 10 11 12",
                       data_out_for_previous1, data_out_for_previous2, data_out_for_previous3);
    end
    read_prev(0, 1);
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3} !== {32'd20, 32'd21, 32'd22}) begin
      errs++; $display("FAIL rdw_new: got %0d %0d %0d expected 20 21 22",
                       data_out_for_previous1, data_out_for_previous2, data_out_for_previous3);
    end
  endtask

  task automatic test_group5();
    logic [31:0] d;
    do_write(5, 99, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
    read_next(15, 99, d);
    vecs++;
    if (d !== 32'hAAAA_0001) begin errs++; $display("FAIL g5_next: got %h expected aaaa0001", d); end
    chk1("g5_no_error", write_error, 1'b0);
    read_prev(5, 99);
    vecs++;
    if ({data_out_for_previous1, data_out_for_previous2, data_out_for_previous3} !== {32'hAAAA_0001, 64'd0}) begin
      errs++; $display("FAIL g5_prev: got %h %h %h expected aaaa0001 0 0",
                       data_out_for_previous1, data_out_for_previous2, data_out_for_previous3);
    end
    read_next(15, 100, d);
    vecs++;
    if (d !== 32'd0) begin errs++; $display("FAIL next_bad_addr: got %h expected 0", d); end
  endtask

  task automatic test_reset_write();
    logic [31:0] d;
    do_write(0, 3, 32'd44, 32'd45, 32'd46);
    reset = 1;
    do_write(0, 3, 32'd55, 32'd56, 32'd57);
    reset = 0;
    read_next(0, 3, d);
    vecs++;
    if (d !== 32'd44) begin errs++; $display("FAIL reset_drops_write: got %0d expected 44", d); end
    chk1("reset_write_no_error", write_error, 1'b0);
  endtask

  task automatic test_bad_writes();
    logic [31:0] d;
    do_write(0, 2, 32'd7, 32'd8, 32'd9);
    do_write(0, 100, 32'd70, 32'd80, 32'd90);
    chk1("addr100_error", write_error, 1'b1);
    tick();
    chk1("error_sticky", write_error, 1'b1);
    do_reset();
    chk1("error_cleared", write_error, 1'b0);
    do_write(6, 2, 32'd71, 32'd81, 32'd91);
    chk1("g6_error", write_error, 1'b1);
    read_next(0, 2, d);
    vecs++;
    if (d !== 32'd7) begin errs++; $display("FAIL bad_write_no_change: got %0d expected 7", d); end
    do_reset();
  endtask

  task automatic test_handshake();
    start_from_previous = 1; tick(); start_from_previous = 0;
    chk1("hs_start_to_next_hi", start_to_next, 1'b1);
    chk1("hs_end_low_handoff", end_to_previous, 1'b0);
    tick();
    chk1("hs_start_to_next_lo", start_to_next, 1'b0);
    chk1("hs_end_low_wait", end_to_previous, 1'b0);
    start_from_previous = 1; tick(); start_from_previous = 0;
    chk1("hs_start_ignored", start_to_next, 1'b0);
    end_from_next = 1; tick(); end_from_next = 0;
    chk1("hs_end_high", end_to_previous, 1'b1);
    // end_from_next already high during HANDOFF: earliest return is two edges later
    start_from_previous = 1; end_from_next = 1; tick(); start_from_previous = 0;
    chk1("hs2_handoff_end", end_to_previous, 1'b0);
    tick();
    chk1("hs2_wait_end", end_to_previous, 1'b0);
    tick(); end_from_next = 0;
    chk1("hs2_idle_end", end_to_previous, 1'b1);
  endtask

  task automatic test_wait_write_reset();
    logic [31:0] d;
    do_write(1, 5, 32'd31, 32'd32, 32'd33);
    start_from_previous = 1; tick(); start_from_previous = 0;
    tick();
    do_write(1, 5, 32'd99, 32'd98, 32'd97);
    chk1("wait_write_error", write_error, 1'b1);
    do_reset();
    chk1("wait_rst_end", end_to_previous, 1'b1);
    chk1("wait_rst_error", write_error, 1'b0);
    read_next(3, 5, d);
    vecs++;
    if (d !== 32'd31) begin errs++; $display("FAIL wait_data_kept: got %0d expected 31", d); end
    read_next(4, 5, d);
    vecs++;
    if (d !== 32'd32) begin errs++; $display("FAIL wait_data_kept2: got %0d expected 32", d); end
  endtask

  task automatic test_full_stream();
    logic [31:0] d;
    for (int g = 0; g <= 5; g++)
      for (int a = 0; a < 100; a++)
        do_write(g, a, pat(3*g, a), pat(3*g+1, a), pat(3*g+2, a));
    chk1("stream_no_error", write_error, 1'b0);
    for (int m = 0; m < 16; m++)
      for (int a = 0; a < 100; a++) begin
        read_next(m, a, d);
        vecs++;
        if (d !== pat(m, a)) begin
          errs++; $display("FAIL stream m%0d a%0d: got %h expected %h", m, a, d, pat(m, a));
        end
      end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_read_during_write();
    test_group5();
    test_reset_write();
    test_bad_writes();
    test_handshake();
    test_wait_write_reset();
    test_full_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
